// File: rtl/tt_factory_pkg.sv
// Shared types and constants for the factory-test memory with BIST.
// Mode and FSM encodings, checkerboard bases and pattern replication.
package tt_factory_pkg;

  typedef enum logic [1:0] {
    MODE_MARCH = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_ADDR  = 2'd2,
    MODE_ALIAS = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [7:0] CB_EVEN = 8'h55;
  localparam logic [7:0] CB_ODD  = 8'hAA;

  localparam int PAT_MAX_W = 256;

  // Callers cast the result down to their word width.
  function automatic logic [PAT_MAX_W-1:0] rep_byte(
    input logic [7:0] b
  );
    logic [PAT_MAX_W-1:0] r;
    for (int i = 0; i < PAT_MAX_W / 8; i++) begin
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_factory_mem_bist_if.sv
// Host access bus of the BIST memory.
// Master drives strobes, address and data; slave returns read data.
interface tt_factory_mem_bist_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 4
);
  logic                      wr_en;
  logic                      rd_en;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rdata_valid;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, rdata_valid
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, rdata_valid
  );
endinterface

// File: rtl/tt_factory_sram.sv
// Register-file memory, synchronous read with one cycle of latency.
// Fault hook: writes to word 0 get bit 0 forced high while inject is set.
module tt_factory_sram #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_DEPTH      = 16,
  parameter int MEM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic                      re,
  input  logic                      inject,
  input  logic [MEM_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] wval;

  always_comb begin
    wval = wdata;
    if (inject && (addr == '0)) begin
      wval[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wval;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tt_factory_mem_bist.sv
// Factory-test memory with BIST: March C-, checkerboard, address-in-data.
// Counts mismatching reads and captures the first failing address.
module tt_factory_mem_bist
  import tt_factory_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_DEPTH      = 16,
  parameter int MEM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic                      inject,
  tt_factory_mem_bist_if.slave      host,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [7:0]                fail_count,
  output logic [MEM_ADDR_WIDTH-1:0] fail_addr
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = MEM_ADDR_WIDTH;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  state_e          state_q, state_d;
  mode_e           mode_q;
  logic [2:0]      elem_q, elem_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            phase_q, phase_d;

  logic            el_rd, el_wr, el_down, el_last;
  logic            nxt_down;
  logic [DW-1:0]   rd_val, wr_val, pat, aval;
  logic            op_rd, op_wr, step_addr, addr_end;

  logic            is_run, is_idle;
  logic            mem_we, mem_re;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_q;

  logic            chk_vld;
  logic [DW-1:0]   chk_exp;
  logic [AW-1:0]   chk_addr;
  logic            mismatch;

  logic            rd_vld;
  logic [DW-1:0]   rdata_hold;

  assign pat  = addr_q[0] ? DW'(rep_byte(CB_ODD))
                          : DW'(rep_byte(CB_EVEN));
  assign aval = DW'(addr_q);

  // Element table: direction, read/write content and data per mode.
  always_comb begin
    el_rd    = 1'b0;
    el_wr    = 1'b0;
    el_down  = 1'b0;
    el_last  = 1'b0;
    nxt_down = 1'b0;
    rd_val   = '0;
    wr_val   = '0;
    unique case (1'b1)
      (mode_q == MODE_CHECK): begin
        el_rd   = elem_q[0];
        el_wr   = !elem_q[0];
        el_last = (elem_q == 3'd3);
        rd_val  = elem_q[1] ? ~pat : pat;
        wr_val  = rd_val;
      end
      (mode_q == MODE_ADDR): begin
        el_rd   = elem_q[0];
        el_wr   = !elem_q[0];
        el_last = elem_q[0];
        rd_val  = aval;
        wr_val  = aval;
      end
      default: begin
        el_rd    = (elem_q != 3'd0);
        el_wr    = (elem_q != 3'd5);
        el_down  = (elem_q >= 3'd3);
        nxt_down = (elem_q >= 3'd2);
        el_last  = (elem_q == 3'd5);
        rd_val   = elem_q[0] ? '0 : ONES;
        wr_val   = elem_q[0] ? ONES : '0;
      end
    endcase
  end

  assign op_rd     = el_rd && !phase_q;
  assign op_wr     = el_wr && (phase_q || !el_rd);
  assign step_addr = !(el_rd && el_wr && !phase_q);
  assign addr_end  = el_down ? (addr_q == '0) : (&addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          elem_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!step_addr) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_end) begin
            elem_d = elem_q + 3'd1;
            addr_d = nxt_down ? {AW{1'b1}} : '0;
            if (el_last) begin
              state_d = ST_DRAIN;
            end
          end else begin
            addr_d = el_down ? addr_q - AW'(1)
                             : addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    is_idle   = (state_q == ST_IDLE);
    is_run    = (state_q == ST_RUN);
    busy      = !is_idle;
    mem_we    = is_run ? op_wr : (is_idle && host.wr_en);
    mem_re    = is_run ? op_rd : (is_idle && host.rd_en);
    mem_addr  = is_run ? addr_q : host.addr;
    mem_wdata = is_run ? wr_val : host.wdata;
  end

  tt_factory_sram #(
    .DATA_WIDTH     (DW),
    .MEM_DEPTH      (MEM_DEPTH),
    .MEM_ADDR_WIDTH (AW)
  ) u_sram (
    .clk    (clk),
    .we     (mem_we),
    .re     (mem_re),
    .inject (inject),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .rdata  (mem_q)
  );

  assign mismatch = chk_vld && (mem_q != chk_exp);

  // Saturation keeps fail_count non-zero once any read has failed.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_MARCH;
      chk_vld    <= 1'b0;
      chk_exp    <= '0;
      chk_addr   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      rd_vld     <= 1'b0;
      rdata_hold <= '0;
    end else begin
      chk_vld  <= is_run && op_rd;
      chk_exp  <= rd_val;
      chk_addr <= addr_q;
      done     <= (state_q == ST_DRAIN);
      rd_vld   <= is_idle && host.rd_en;
      if (rd_vld) begin
        rdata_hold <= mem_q;
      end
      if (is_idle && start) begin
        mode_q     <= (mode == MODE_ALIAS) ? MODE_MARCH
                                           : mode_e'(mode);
        fail_count <= '0;
        fail_addr  <= '0;
        pass       <= 1'b0;
      end else begin
        if (mismatch) begin
          if (fail_count != 8'hFF) begin
            fail_count <= fail_count + 8'd1;
          end
          if (fail_count == 8'd0) begin
            fail_addr <= chk_addr;
          end
        end
        if (state_q == ST_DRAIN) begin
          pass <= (fail_count == 8'd0) && !mismatch;
        end
      end
    end
  end

  assign host.rdata       = rd_vld ? mem_q : rdata_hold;
  assign host.rdata_valid = rd_vld;

endmodule

// File: tb/tb_tt_factory_mem_bist.sv
// Bench for tt_factory_mem_bist: op-list reference model plus
// directed scenarios and randomized host/BIST traffic.
module tb_tt_factory_mem_bist;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          inject = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          busy, done, pass;
  logic [7:0]    fail_count;
  logic [AW-1:0] fail_addr;

  int checks = 0;
  int errors = 0;

  tt_factory_mem_bist_if #(
    .DATA_WIDTH     (DW),
    .MEM_ADDR_WIDTH (AW)
  ) host ();

  tt_factory_mem_bist #(
    .DATA_WIDTH     (DW),
    .MEM_DEPTH      (D),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .inject     (inject),
    .host       (host),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_addr  (fail_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a run is the list of ops the algorithm
  // defines, consumed one per cycle.
  typedef struct {
    bit         rd;
    int         a;
    logic [7:0] d;
  } op_t;

  op_t        q[$];
  logic [7:0] m_mem [D];
  bit         model_ok = 0;
  bit         m_busy = 0, m_done = 0, m_pass = 0, m_rv = 0;
  int         m_fc = 0, m_fa = 0;
  logic [7:0] m_rdata = 0;
  bit         pend = 0;
  logic [7:0] p_got, p_exp;
  int         p_a;

  function automatic logic [7:0] cbp(int a);
    return (a % 2 == 1) ? 8'hAA : 8'h55;
  endfunction

  task automatic push(bit rd, int a, logic [7:0] d);
    op_t o;
    o.rd = rd;
    o.a  = a;
    o.d  = d;
    q.push_back(o);
  endtask

  task automatic build(int md);
    q.delete();
    if (md == 1) begin
      for (int a = 0; a < D; a++) push(0, a, cbp(a));
      for (int a = 0; a < D; a++) push(1, a, cbp(a));
      for (int a = 0; a < D; a++) push(0, a, ~cbp(a));
      for (int a = 0; a < D; a++) push(1, a, ~cbp(a));
    end else if (md == 2) begin
      for (int a = 0; a < D; a++) push(0, a, 8'(a));
      for (int a = 0; a < D; a++) push(1, a, 8'(a));
    end else begin
      for (int a = 0; a < D; a++) push(0, a, 8'h00);
      for (int a = 0; a < D; a++) begin
        push(1, a, 8'h00); push(0, a, 8'hFF);
      end
      for (int a = 0; a < D; a++) begin
        push(1, a, 8'hFF); push(0, a, 8'h00);
      end
      for (int a = D - 1; a >= 0; a--) begin
        push(1, a, 8'h00); push(0, a, 8'hFF);
      end
      for (int a = D - 1; a >= 0; a--) begin
        push(1, a, 8'hFF); push(0, a, 8'h00);
      end
      for (int a = D - 1; a >= 0; a--) push(1, a, 8'h00);
    end
  endtask

  task automatic mwrite(int a, logic [7:0] d);
    m_mem[a] = (inject && a == 0) ? (d | 8'h01) : d;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1;
      m_busy = 0; m_done = 0; m_pass = 0; m_rv = 0;
      m_fc = 0; m_fa = 0; m_rdata = 0; pend = 0;
      q.delete();
    end else begin
      m_done = 0;
      m_rv = 0;
      if (!m_busy) begin
        if (host.rd_en) begin
          m_rv = 1;
          m_rdata = m_mem[host.addr];
        end
        if (host.wr_en) mwrite(int'(host.addr), host.wdata);
        if (start) begin
          build(int'(mode));
          m_busy = 1; m_fc = 0; m_fa = 0; m_pass = 0; pend = 0;
        end
      end else begin
        if (pend) begin
          pend = 0;
          if (p_got !== p_exp) begin
            if (m_fc == 0) m_fa = p_a;
            if (m_fc < 255) m_fc++;
          end
        end
        if (q.size() > 0) begin
          op_t o;
          o = q.pop_front();
          if (o.rd) begin
            pend = 1;
            p_got = m_mem[o.a];
            p_exp = o.d;
            p_a = o.a;
          end else begin
            mwrite(o.a, o.d);
          end
        end else begin
          m_busy = 0;
          m_done = 1;
          m_pass = (m_fc == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("fail_count", 32'(fail_count), 32'(m_fc));
      check("fail_addr", 32'(fail_addr), 32'(m_fa));
      check("rdata_valid", 32'(host.rdata_valid), 32'(m_rv));
      check("rdata", 32'(host.rdata), 32'(m_rdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(int a, logic [7:0] d);
    host.wr_en = 1'b1;
    host.addr  = AW'(a);
    host.wdata = d;
    tick();
    host.wr_en = 1'b0;
  endtask

  task automatic hread(int a);
    host.rd_en = 1'b1;
    host.addr  = AW'(a);
    tick();
    host.rd_en = 1'b0;
  endtask

  task automatic start_run(int md, bit inj);
    mode   = 2'(md);
    inject = inj;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Entered in cycle N+1; poke > 0 injects start and a write mid-run.
  task automatic run_wait(input string nm, input int exp_done,
                          input int exp_busy, input int poke);
    int bcnt = 0;
    int dat = 0;
    for (int i = 1; i <= 400; i++) begin
      if (done === 1'b1) begin
        dat = i;
        break;
      end
      if (busy === 1'b1) bcnt++;
      if (i == poke) begin
        start = 1'b1;
        host.wr_en = 1'b1;
        host.addr = AW'(3);
        host.wdata = 8'hFF;
      end
      tick();
      start = 1'b0;
      host.wr_en = 1'b0;
    end
    check({nm, "_done_cycle"}, 32'(dat), 32'(exp_done));
    check({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
  endtask

  initial begin
    host.wr_en = 1'b0;
    host.rd_en = 1'b0;
    host.addr  = '0;
    host.wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    check("rst_rdata", 32'(host.rdata), 32'd0);

    hwrite(5, 8'h3C);
    hread(5);
    check("host_rd_valid", 32'(host.rdata_valid), 32'd1);
    check("host_rd_data", 32'(host.rdata), 32'h3C);
    tick();
    check("host_rd_valid_drop", 32'(host.rdata_valid), 32'd0);
    check("host_rd_hold", 32'(host.rdata), 32'h3C);

    start_run(0, 0);
    run_wait("march", 162, 161, 0);
    check("march_pass", 32'(pass), 32'd1);
    check("march_fc", 32'(fail_count), 32'd0);
    hread(7);
    check("march_word7", 32'(host.rdata), 32'h00);

    start_run(1, 1);
    run_wait("cb_inj", 66, 65, 0);
    check("cb_inj_pass", 32'(pass), 32'd0);
    check("cb_inj_fc", 32'(fail_count), 32'd1);
    check("cb_inj_fa", 32'(fail_addr), 32'd0);

    start_run(2, 1);
    run_wait("aid_inj", 34, 33, 0);
    check("aid_inj_pass", 32'(pass), 32'd0);
    check("aid_inj_fc", 32'(fail_count), 32'd1);
    check("aid_inj_fa", 32'(fail_addr), 32'd0);

    start_run(2, 0);
    run_wait("aid_poke", 34, 33, 5);
    check("aid_poke_pass", 32'(pass), 32'd1);
    hread(3);
    check("aid_word3", 32'(host.rdata), 32'h03);

    start_run(0, 0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_fc", 32'(fail_count), 32'd0);
    start_run(0, 0);
    run_wait("rerun", 162, 161, 0);
    check("rerun_pass", 32'(pass), 32'd1);

    for (int i = 0; i < 600; i++) begin
      host.wr_en = ($urandom % 3) == 0;
      host.rd_en = ($urandom % 3) == 0;
      host.addr  = AW'($urandom);
      host.wdata = DW'($urandom);
      inject     = ($urandom % 8) == 0;
      start      = ($urandom % 40) == 0;
      mode       = 2'($urandom);
      tick();
    end
    host.wr_en = 1'b0;
    host.rd_en = 1'b0;
    inject = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    check("final_idle", 32'(busy), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
